// File: rtl/adder_4b_pkg.sv
// ---------------------------------------------------------------------------
// adder_4b_pkg
//   Shared constants for the 4-bit ripple-carry adder slice.
//   ADDER_W : operand / sum width in bits.
//   RST_VAL : value loaded into the {carry, sum} result register on reset.
// ---------------------------------------------------------------------------
package adder_4b_pkg;

    localparam int unsigned ADDER_W = 4;

    localparam logic [ADDER_W:0] RST_VAL = 5'b0_0000;

endpackage : adder_4b_pkg

// File: rtl/adder_4b_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder, one stage of the adder_4b ripple chain.
//   Ports:
//     a, b  : operand bits
//     cin   : carry into this stage
//     sum   : a ^ b ^ cin
//     cout  : carry out of this stage
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;  // propagate
    logic g;  // generate

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        sum  = p ^ cin;
        cout = g | (cin & p);
    end

endmodule : full_adder

// File: rtl/adder_4b.sv
// ---------------------------------------------------------------------------
// adder_4b
//   4-bit ripple-carry adder with carry-in and carry-out, plus a registered
//   copy of the result for clocked consumers.
//   Ports:
//     clk         : system clock (only clock)
//     rst_n       : synchronous active-low reset; clears only the registers
//     carryIn     : carry into bit 0
//     in1, in2    : unsigned 4-bit operands
//     out         : combinational sum bits [3:0]
//     carryOut    : combinational carry out of bit 3
//     out_r       : out registered on every rising clk edge
//     carry_out_r : carryOut registered on every rising clk edge
//   Signed overflow is not flagged; consumers derive it from in1[3], in2[3]
//   and out[3].
// ---------------------------------------------------------------------------
module adder_4b
    import adder_4b_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carryIn,
    input  logic [ADDER_W-1:0] in1,
    input  logic [ADDER_W-1:0] in2,
    output logic [ADDER_W-1:0] out,
    output logic               carryOut,
    output logic [ADDER_W-1:0] out_r,
    output logic               carry_out_r
);

    // c[0] is the external carry-in, c[ADDER_W] the final carry-out.
    logic [ADDER_W:0]   c;
    logic [ADDER_W-1:0] s;
    logic [ADDER_W:0]   res_r;

    assign c[0] = carryIn;

    for (genvar i = 0; i < ADDER_W; i++) begin : g_stage
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    assign out      = s;
    assign carryOut = c[ADDER_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_r <= RST_VAL;
        end else begin
            res_r <= {c[ADDER_W], s};
        end
    end

    assign out_r       = res_r[ADDER_W-1:0];
    assign carry_out_r = res_r[ADDER_W];

endmodule : adder_4b

// File: tb/tb_adder_4b.sv
// ---------------------------------------------------------------------------
// tb_adder_4b
//   Directed and exhaustive checks of adder_4b: combinational sum/carry,
//   registered copy, and synchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_adder_4b;

    logic       clk;
    logic       rst_n;
    logic       carryIn;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] out;
    logic       carryOut;
    logic [3:0] out_r;
    logic       carry_out_r;

    int unsigned chk_cnt;
    int unsigned pass_cnt;

    adder_4b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .carryIn     (carryIn),
        .in1         (in1),
        .in2         (in2),
        .out         (out),
        .carryOut    (carryOut),
        .out_r       (out_r),
        .carry_out_r (carry_out_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Directed vectors: {carryIn, in1, in2, expected {carryOut, out}}
    typedef struct {
        logic       ci;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst_n    = 1'b0;
        carryIn  = 1'b0;
        in1      = 4'b0000;
        in2      = 4'b0000;

        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 5'b0_0000};
        vecs[1] = '{1'b1, 4'b0000, 4'b0000, 5'b0_0001};
        vecs[2] = '{1'b0, 4'b0101, 4'b0101, 5'b0_1010};
        vecs[3] = '{1'b1, 4'b0101, 4'b0101, 5'b0_1011};
        vecs[4] = '{1'b0, 4'b1010, 4'b1010, 5'b1_0100};
        vecs[5] = '{1'b1, 4'b1010, 4'b1010, 5'b1_0101};
        vecs[6] = '{1'b0, 4'b1111, 4'b1111, 5'b1_1110};
        vecs[7] = '{1'b1, 4'b1111, 4'b1111, 5'b1_1111};

        // Combinational directed vectors (changed away from edges).
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            carryIn = vecs[i].ci;
            in1     = vecs[i].a;
            in2     = vecs[i].b;
            #1;
            check($sformatf("comb_vec%0d", i), {carryOut, out}, vecs[i].exp);
        end

        // Reset held for 2 edges with max inputs: registers stay clear.
        @(negedge clk);
        carryIn = 1'b1;
        in1     = 4'b1111;
        in2     = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_reg", {carry_out_r, out_r}, 5'b0_0000);
        check("reset_comb", {carryOut, out}, 5'b1_1111);

        // Release: first edge captures the current sum.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_reg", {carry_out_r, out_r}, 5'b1_1111);

        // Input change between edges: register holds until the next edge.
        @(negedge clk);
        carryIn = 1'b0;
        in1     = 4'b0101;
        in2     = 4'b0101;
        #1;
        check("hold_reg", {carry_out_r, out_r}, 5'b1_1111);
        check("hold_comb", {carryOut, out}, 5'b0_1010);
        @(posedge clk);
        #1;
        check("update_reg", {carry_out_r, out_r}, 5'b0_1010);

        // Exhaustive sweep; reset asserted for one edge mid-way.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] exp;
            v = 9'(i);
            @(negedge clk);
            carryIn = v[8];
            in1     = v[7:4];
            in2     = v[3:0];
            rst_n   = (i != 256);
            exp     = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
            #1;
            check($sformatf("sweep_comb_%0d", i), {carryOut, out}, exp);
            @(posedge clk);
            #1;
            if (i == 256) begin
                check("sweep_reset_reg", {carry_out_r, out_r}, 5'b0_0000);
                check("sweep_reset_comb", {carryOut, out}, exp);
            end else begin
                check($sformatf("sweep_reg_%0d", i), {carry_out_r, out_r}, exp);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_adder_4b
